// File: rtl/sha3_wb_absorb.sv
// Wishbone slave that packs 32-bit message words little-endian into a SHA3 rate block,
// applies 0x06..0x80 domain padding on the final word and hands blocks to the core.
module sha3_wb_absorb #(
    parameter int          RATE_LANES = 17,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [RATE_LANES*64-1:0] blk_o,
    output logic                     blk_valid_o,
    output logic                     blk_last_o,
    input  logic                     blk_ready_i
);
    localparam int RATE_BYTES = RATE_LANES * 8;
    localparam int RATE_WORDS = RATE_LANES * 2;
    localparam int CNT_W      = $clog2(RATE_WORDS + 1);
    localparam int IDX_W      = $clog2(RATE_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(RATE_WORDS - 1);

    typedef enum logic [0:0] {FILL, PEND} state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        word_cnt_reg;
    logic [RATE_BYTES*8-1:0] buf_reg;
    logic                    ack_reg;
    logic [31:0]             dat_reg;
    logic                    valid_reg;
    logic                    last_reg;

    logic                    decode;
    logic [3:0]              offset;
    logic                    is_ctrl;
    logic                    is_data;
    logic                    is_final;
    logic [2:0]              fin_n;
    logic                    illegal_final;
    logic                    stall;
    logic                    accept;
    logic [31:0]             read_data;
    logic [IDX_W-1:0]        p_pos;
    logic [IDX_W-1:0]        pad_pos;
    logic [RATE_BYTES*8-1:0] final_buf;

    assign decode   = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign offset   = wbs_adr_i[3:0];
    assign is_ctrl  = wbs_we_i && (offset == 4'h0);
    assign is_data  = wbs_we_i && (offset == 4'h4);
    assign is_final = wbs_we_i && (offset == 4'h8);

    // Valid byte count is the run of ones in sel starting at bit 0.
    always_comb begin
        fin_n = 3'd0;
        if (wbs_sel_i[0]) begin
            fin_n = 3'd1;
            if (wbs_sel_i[1]) begin
                fin_n = 3'd2;
                if (wbs_sel_i[2]) begin
                    fin_n = 3'd3;
                    if (wbs_sel_i[3]) begin
                        fin_n = 3'd4;
                    end
                end
            end
        end
    end

    // A full final word in the last slot would leave no room for the 0x06 pad byte.
    assign illegal_final = is_final && (word_cnt_reg == LAST_WORD) && (fin_n == 3'd4);
    assign stall  = ((state_reg == PEND) && (is_ctrl || is_data || is_final)) || illegal_final;
    // Blocking on ack_reg keeps a held strobe from being acked twice for one request.
    assign accept = wbs_cyc_i && wbs_stb_i && decode && !ack_reg && !stall;

    assign read_data = (offset == 4'hC)
                     ? {16'h0000, 8'(word_cnt_reg), 6'b000000, last_reg, valid_reg}
                     : 32'h0000_0000;

    assign p_pos   = IDX_W'({word_cnt_reg, 2'b00});
    assign pad_pos = p_pos + IDX_W'(fin_n);

    // Final block image: keep earlier words, insert the partial word, zero the tail, pad.
    genvar gi;
    generate
        for (gi = 0; gi < RATE_BYTES; gi++) begin : g_final
            localparam logic [IDX_W-1:0] POS  = IDX_W'(gi);
            localparam logic [7:0]       TAIL = (gi == RATE_BYTES - 1) ? 8'h80 : 8'h00;
            logic [7:0] fill_byte;

            always_comb begin
                if (POS < p_pos) begin
                    fill_byte = buf_reg[gi*8 +: 8];
                end else if (POS < pad_pos) begin
                    fill_byte = wbs_dat_i[(gi % 4)*8 +: 8];
                end else begin
                    fill_byte = 8'h00;
                end
            end

            assign final_buf[gi*8 +: 8] = fill_byte | ((POS == pad_pos) ? 8'h06 : 8'h00) | TAIL;
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= FILL;
            word_cnt_reg <= '0;
            buf_reg      <= '0;
            ack_reg      <= 1'b0;
            dat_reg      <= 32'h0000_0000;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
        end else begin
            ack_reg <= accept;
            dat_reg <= (accept && !wbs_we_i) ? read_data : 32'h0000_0000;
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        if (is_ctrl && wbs_dat_i[0]) begin
                            buf_reg      <= '0;
                            word_cnt_reg <= '0;
                        end else if (is_data) begin
                            buf_reg[{word_cnt_reg, 5'b00000} +: 32] <= wbs_dat_i;
                            word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                            if (word_cnt_reg == LAST_WORD) begin
                                valid_reg <= 1'b1;
                                last_reg  <= 1'b0;
                                state_reg <= PEND;
                            end
                        end else if (is_final) begin
                            buf_reg   <= final_buf;
                            valid_reg <= 1'b1;
                            last_reg  <= 1'b1;
                            state_reg <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (valid_reg && blk_ready_i) begin
                        buf_reg      <= '0;
                        word_cnt_reg <= '0;
                        valid_reg    <= 1'b0;
                        last_reg     <= 1'b0;
                        state_reg    <= FILL;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = dat_reg;
    assign blk_o       = buf_reg;
    assign blk_valid_o = valid_reg;
    assign blk_last_o  = last_reg;

endmodule

// File: tb/tb_sha3_wb_absorb.sv
// Directed bench for sha3_wb_absorb: a message/byte-queue model checked every cycle,
// plus hand-computed block literals for the key scenarios.
module tb_sha3_wb_absorb;
    localparam int          RB   = 136;
    localparam int          RW   = 34;
    localparam int          BW   = RB * 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    typedef logic [BW-1:0] blk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat_w = 32'h0;
    logic        rdy = 1'b0;

    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    blk_t        blk_o;
    logic        blk_valid_o;
    logic        blk_last_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bytes of the block being absorbed, word count, and the pending block.
    logic [7:0] m_msg[$];
    int         m_words = 0;
    bit         m_valid = 0;
    bit         m_last  = 0;
    blk_t       m_blk   = '0;

    sha3_wb_absorb dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_w),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .blk_o       (blk_o),
        .blk_valid_o (blk_valid_o),
        .blk_last_o  (blk_last_o),
        .blk_ready_i (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input blk_t act, input blk_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ones_run(input logic [3:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] && n == i) n++;
        end
        return n;
    endfunction

    function automatic blk_t pack(input logic [7:0] q[$], input bit last);
        blk_t b = '0;
        for (int i = 0; i < q.size(); i++) b[i*8 +: 8] = q[i];
        if (last) begin
            b[q.size()*8 +: 8] = b[q.size()*8 +: 8] | 8'h06;
            b[BW-8 +: 8]       = b[BW-8 +: 8] | 8'h80;
        end
        return b;
    endfunction

    task automatic model_clear();
        m_msg.delete();
        m_words = 0;
        m_valid = 0;
        m_last  = 0;
    endtask

    task automatic model_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
        int n;
        if (off == 4'h0 && d[0]) begin
            m_msg.delete();
            m_words = 0;
        end else if (off == 4'h4) begin
            for (int i = 0; i < 4; i++) m_msg.push_back(d[i*8 +: 8]);
            m_words++;
            if (m_words == RW) begin
                m_blk   = pack(m_msg, 1'b0);
                m_valid = 1;
                m_last  = 0;
            end
        end else if (off == 4'h8) begin
            n = ones_run(s);
            for (int i = 0; i < n; i++) m_msg.push_back(d[i*8 +: 8]);
            m_blk   = pack(m_msg, 1'b1);
            m_valid = 1;
            m_last  = 1;
        end
    endtask

    // Per-cycle compare: inputs seen at the edge, outputs checked 2 time units later.
    initial begin : compare
        logic        s_req, s_we, s_rst, s_rdy;
        logic [31:0] s_adr, s_dat;
        logic [3:0]  s_sel, off;
        bit          exp_ack, prev_ack, allowed;
        logic [31:0] exp_rd;
        prev_ack = 0;
        forever begin
            @(posedge clk);
            s_req = cyc && stb && (adr[31:4] == BASE[31:4]);
            s_we  = we;
            s_rst = rst;
            s_rdy = rdy;
            s_adr = adr;
            s_dat = dat_w;
            s_sel = sel;
            #2;
            if (s_rst) begin
                model_clear();
                exp_ack = 0;
                check("ack_in_reset", blk_t'(wbs_ack_o), blk_t'(exp_ack));
            end else begin
                off = s_adr[3:0];
                allowed = !(s_we && (off == 4'h0 || off == 4'h4 || off == 4'h8) &&
                            (m_valid || (off == 4'h8 && m_words == RW - 1 && ones_run(s_sel) == 4)));
                exp_ack = s_req && !prev_ack && allowed;
                check("ack", blk_t'(wbs_ack_o), blk_t'(exp_ack));
                if (exp_ack && !s_we) begin
                    exp_rd = (off == 4'hC) ? {16'h0, 8'(m_words), 6'h0, m_last, m_valid} : 32'h0;
                    check("rdata", blk_t'(wbs_dat_o), blk_t'(exp_rd));
                end
                if (exp_ack && s_we) model_write(off, s_dat, s_sel);
                else if (m_valid && s_rdy) model_clear();
            end
            prev_ack = exp_ack;
            check("valid", blk_t'(blk_valid_o), blk_t'(m_valid));
            check("last", blk_t'(blk_last_o), blk_t'(m_last));
            if (m_valid) check("blk", blk_o, m_blk);
        end
    end

    // Called on a negedge; returns on the negedge where ack was seen or the budget ran out.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int maxc,
                           output bit acked, output logic [31:0] rd, output int ncyc);
        cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s;
        acked = 0; rd = 32'h0; ncyc = 0;
        while (!acked && ncyc < maxc) begin
            @(negedge clk);
            ncyc++;
            if (wbs_ack_o) begin
                acked = 1;
                rd = wbs_dat_o;
            end
        end
        cyc = 0; stb = 0; we = 0;
        $display("[TB] xfer we=%0b adr=%h dat=%h sel=%b acked=%0b cycles=%0d", w, a, d, s, acked, ncyc);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
        bit ok; logic [31:0] rd; int nc;
        wb_xfer(1'b1, BASE | {28'h0, off}, d, s, 10, ok, rd, nc);
        check("write_acked", blk_t'(ok), blk_t'(1'b1));
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        bit ok; logic [31:0] rd; int nc;
        wb_xfer(1'b0, BASE | 32'hC, 32'h0, 4'hF, 10, ok, rd, nc);
        check({name, "_acked"}, blk_t'(ok), blk_t'(1'b1));
        check(name, blk_t'(rd), blk_t'(exp));
    endtask

    task automatic handshake();
        rdy = 1;
        @(negedge clk);
        rdy = 0;
        check("hs_valid_drop", blk_t'(blk_valid_o), blk_t'(1'b0));
    endtask

    initial begin : main
        bit          ok;
        logic [31:0] rd;
        int          nc;
        blk_t        empty_blk, lit;
        empty_blk = '0;
        empty_blk[7:0] = 8'h06;
        empty_blk[BW-1 -: 8] = 8'h80;

        repeat (3) @(negedge clk);
        check("rst_ack", blk_t'(wbs_ack_o), '0);
        check("rst_dat", blk_t'(wbs_dat_o), '0);
        check("rst_valid", blk_t'(blk_valid_o), '0);
        check("rst_last", blk_t'(blk_last_o), '0);
        check("rst_blk", blk_o, '0);
        rst = 0;
        @(negedge clk);

        // Empty message
        wr(4'h8, 32'h0, 4'b0000);
        @(negedge clk);
        check("empty_last", blk_t'(blk_last_o), blk_t'(1'b1));
        check("empty_blk", blk_o, empty_blk);
        handshake();

        // CTRL clear then "abc"
        wr(4'h4, 32'hAABBCCDD, 4'hF);
        wr(4'h4, 32'hAABBCCDD, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        wr(4'h8, 32'h00636261, 4'b0111);
        lit = '0;
        lit[31:0] = 32'h06636261;
        lit[BW-1 -: 8] = 8'h80;
        check("abc_blk", blk_o, lit);
        check("abc_last", blk_t'(blk_last_o), blk_t'(1'b1));
        handshake();

        // Full block, status during PEND, stalled 35th write
        for (int i = 0; i < RW; i++) wr(4'h4, 32'h11111111, 4'hF);
        check("full_blk", blk_o, {RB{8'h11}});
        check("full_last", blk_t'(blk_last_o), '0);
        rd_status("status_pend", 32'h00002201);
        fork
            wb_xfer(1'b1, BASE | 32'h4, 32'h11111111, 4'hF, 20, ok, rd, nc);
            begin
                repeat (5) @(negedge clk);
                rdy = 1;
                @(negedge clk);
                rdy = 0;
            end
        join
        check("stall_acked", blk_t'(ok), blk_t'(1'b1));
        check("stall_cycles", blk_t'(nc), blk_t'(7));
        rd_status("status_after_stall", 32'h00000100);

        // 33 words, illegal full FINAL rejected, then pad collision
        for (int i = 1; i < RW - 1; i++) wr(4'h4, 32'h11111111, 4'hF);
        wb_xfer(1'b1, BASE | 32'h8, 32'hDDCCBBAA, 4'b1111, 5, ok, rd, nc);
        check("illegal_final_noack", blk_t'(ok), '0);
        @(negedge clk);
        wr(4'h8, 32'h00CCBBAA, 4'b0111);
        lit = {RB{8'h11}};
        lit[BW-1 -: 32] = 32'h86CCBBAA;
        check("collision_blk", blk_o, lit);
        handshake();

        // Block boundary then padding-only FINAL
        for (int i = 0; i < RW; i++) wr(4'h4, 32'h22222222, 4'hF);
        check("boundary_blk", blk_o, {RB{8'h22}});
        handshake();
        wr(4'h8, 32'hFFFFFFFF, 4'b0000);
        check("boundary_pad_blk", blk_o, empty_blk);
        handshake();

        // Undecoded access and read of a write-only offset
        wb_xfer(1'b1, 32'h4000_0004, 32'h12345678, 4'hF, 4, ok, rd, nc);
        check("undecoded_noack", blk_t'(ok), '0);
        @(negedge clk);
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, 10, ok, rd, nc);
        check("read_ctrl_acked", blk_t'(ok), blk_t'(1'b1));
        check("read_ctrl_zero", blk_t'(rd), '0);

        // Reset mid-block
        for (int i = 0; i < 10; i++) wr(4'h4, 32'h33333333, 4'hF);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_valid", blk_t'(blk_valid_o), '0);
        rd_status("midrst_status", 32'h00000000);
        wr(4'h8, 32'h0, 4'b0000);
        check("midrst_empty_blk", blk_o, empty_blk);
        handshake();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
